// File: rtl/sram_arbiter.sv
// sram_arbiter: shares a 256Kx16 async SRAM between the ULA video fetcher
// (read-only, fixed high priority) and the Z80 CPU (read/write), byte-addressed.
// All SRAM pins and acks are registered; strobes are active low.
module sram_arbiter #(
    parameter int RD_CYCLES = 2,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_req,
    input  logic [18:0] v_addr,
    output logic        v_ack,
    output logic [7:0]  v_dout,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [18:0] c_addr,
    input  logic [7:0]  c_din,
    output logic        c_ack,
    output logic [7:0]  c_dout,
    output logic        c_wait,
    output logic [17:0] sa,
    inout  wire  [15:0] sd,
    output logic        sramce,
    output logic        sramub,
    output logic        sramlb,
    output logic        sramoe,
    output logic        sramwe
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        own_v_q, own_v_d;
    logic        lane_q, lane_d;
    logic [17:0] sa_q, sa_d;
    logic        ce_q, ce_d, oe_q, oe_d, we_q, we_d, ub_q, ub_d, lb_q, lb_d;
    logic        sd_oe_q, sd_oe_d;
    logic [15:0] sd_out_q, sd_out_d;
    logic        v_ack_q, v_ack_d, c_ack_q, c_ack_d;
    logic [7:0]  v_dout_q, v_dout_d, c_dout_q, c_dout_d;
    logic [7:0]  lane_byte;

    assign lane_byte = lane_q ? sd[15:8] : sd[7:0];

    // Next-state, strobe and ack computation; an ack still high masks its requester.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_v_d  = own_v_q;
        lane_d   = lane_q;
        sa_d     = sa_q;
        ce_d     = ce_q;
        oe_d     = oe_q;
        we_d     = we_q;
        ub_d     = ub_q;
        lb_d     = lb_q;
        sd_oe_d  = sd_oe_q;
        sd_out_d = sd_out_q;
        v_ack_d  = 1'b0;
        c_ack_d  = 1'b0;
        v_dout_d = v_dout_q;
        c_dout_d = c_dout_q;
        case (state_q)
            IDLE: begin
                if (v_req && !v_ack_q) begin
                    own_v_d = 1'b1;
                    sa_d    = v_addr[18:1];
                    lane_d  = v_addr[0];
                    ub_d    = ~v_addr[0];
                    lb_d    = v_addr[0];
                    ce_d    = 1'b0;
                    oe_d    = 1'b0;
                    we_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = RD;
                end else if (c_req && !c_ack_q) begin
                    own_v_d = 1'b0;
                    sa_d    = c_addr[18:1];
                    lane_d  = c_addr[0];
                    ub_d    = ~c_addr[0];
                    lb_d    = c_addr[0];
                    ce_d    = 1'b0;
                    we_d    = 1'b1;
                    cnt_d   = '0;
                    if (c_we) begin
                        oe_d     = 1'b1;
                        sd_oe_d  = 1'b1;
                        sd_out_d = {c_din, c_din};
                        state_d  = WR_SETUP;
                    end else begin
                        oe_d    = 1'b0;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (cnt_q == RD_LAST) begin
                    if (own_v_q) begin
                        v_dout_d = lane_byte;
                        v_ack_d  = 1'b1;
                    end else begin
                        c_dout_d = lane_byte;
                        c_ack_d  = 1'b1;
                    end
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_SETUP: begin
                we_d    = 1'b0;
                cnt_d   = '0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == WR_LAST) begin
                    we_d    = 1'b1;
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_HOLD: begin
                c_ack_d = 1'b1;
                sd_oe_d = 1'b0;
                ce_d    = 1'b1;
                ub_d    = 1'b1;
                lb_d    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered pin/ack outputs; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            own_v_q  <= 1'b0;
            lane_q   <= 1'b0;
            sa_q     <= '0;
            ce_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            ub_q     <= 1'b1;
            lb_q     <= 1'b1;
            sd_oe_q  <= 1'b0;
            sd_out_q <= '0;
            v_ack_q  <= 1'b0;
            c_ack_q  <= 1'b0;
            v_dout_q <= '0;
            c_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            own_v_q  <= own_v_d;
            lane_q   <= lane_d;
            sa_q     <= sa_d;
            ce_q     <= ce_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            ub_q     <= ub_d;
            lb_q     <= lb_d;
            sd_oe_q  <= sd_oe_d;
            sd_out_q <= sd_out_d;
            v_ack_q  <= v_ack_d;
            c_ack_q  <= c_ack_d;
            v_dout_q <= v_dout_d;
            c_dout_q <= c_dout_d;
        end
    end

    assign sd     = sd_oe_q ? sd_out_q : 16'bz;
    assign sa     = sa_q;
    assign sramce = ce_q;
    assign sramoe = oe_q;
    assign sramwe = we_q;
    assign sramub = ub_q;
    assign sramlb = lb_q;
    assign v_ack  = v_ack_q;
    assign c_ack  = c_ack_q;
    assign v_dout = v_dout_q;
    assign c_dout = c_dout_q;
    assign c_wait = c_req & ~c_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus, pin-level SRAM model, and a transaction
// model that predicts strobes/acks/data cycle by cycle from the access rules.
module tb_sram_arbiter;

    localparam int RD = 2;
    localparam int WR = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_req = 1'b0;
    logic [18:0] v_addr = '0;
    logic        v_ack;
    logic [7:0]  v_dout;
    logic        c_req = 1'b0;
    logic        c_we = 1'b0;
    logic [18:0] c_addr = '0;
    logic [7:0]  c_din = '0;
    logic        c_ack;
    logic [7:0]  c_dout;
    logic        c_wait;
    logic [17:0] sa;
    wire  [15:0] sd;
    logic        sramce, sramub, sramlb, sramoe, sramwe;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter #(.RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
        .clk(clk), .rst_n(rst_n),
        .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_dout(v_dout),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_din(c_din),
        .c_ack(c_ack), .c_dout(c_dout), .c_wait(c_wait),
        .sa(sa), .sd(sd),
        .sramce(sramce), .sramub(sramub), .sramlb(sramlb),
        .sramoe(sramoe), .sramwe(sramwe)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [18:0] a);
        return a[7:0] ^ {a[15:12], a[18:16], 1'b1} ^ 8'h3C;
    endfunction

    // ---------------- pin-level SRAM ----------------
    logic [7:0]  pin_mem [int];
    logic [15:0] rd_word = '0;

    function automatic logic [7:0] pin_rd(input logic [18:0] a);
        return pin_mem.exists(int'(a)) ? pin_mem[int'(a)] : init_byte(a);
    endfunction

    assign sd = (!sramce && !sramoe && sramwe) ? rd_word : 16'bz;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!sramce && !sramwe) begin
                if (!sramlb) pin_mem[int'({sa, 1'b0})] = sd[7:0];
                if (!sramub) pin_mem[int'({sa, 1'b1})] = sd[15:8];
            end
            rd_word = {pin_rd({sa, 1'b1}), pin_rd({sa, 1'b0})};
        end
    end

    // ---------------- transaction model ----------------
    logic [7:0]  ref_mem [int];
    bit          m_busy = 0, m_wr = 0, m_vown = 0;
    int          m_k = 0, m_len = 0;
    logic [18:0] m_addr = '0;
    logic [7:0]  m_din = '0;
    logic        e_ce = 1, e_oe = 1, e_we = 1, e_ub = 1, e_lb = 1;
    logic        e_vack = 0, e_cack = 0;
    logic [17:0] e_sa = '0;
    logic [7:0]  e_vdout = '0, e_cdout = '0;
    logic [15:0] e_sd = '0;

    function automatic logic [7:0] ref_rd(input logic [18:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    // k counts strobe cycles of the current access, 1-based
    task automatic set_strobes();
        e_ce = 0;
        e_sa = m_addr[18:1];
        e_ub = ~m_addr[0];
        e_lb = m_addr[0];
        if (!m_wr) begin
            e_oe = 0;
            e_we = 1;
        end else begin
            e_oe = 1;
            e_we = (m_k >= 2 && m_k <= WR + 1) ? 1'b0 : 1'b1;
            e_sd = {m_din, m_din};
        end
    endtask

    task automatic model_step();
        bit pv, pc, g;
        if (!rst_n) begin
            m_busy = 0;
            e_ce = 1; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1;
            e_vack = 0; e_cack = 0; e_sa = '0; e_vdout = '0; e_cdout = '0;
            return;
        end
        pv = e_vack;
        pc = e_cack;
        e_vack = 0;
        e_cack = 0;
        if (m_busy) begin
            m_k++;
            if (m_k > m_len) begin
                m_busy = 0;
                e_ce = 1; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1;
                if (m_wr) begin
                    ref_mem[int'(m_addr)] = m_din;
                    e_cack = 1;
                end else if (m_vown) begin
                    e_vack = 1;
                    e_vdout = ref_rd(m_addr);
                end else begin
                    e_cack = 1;
                    e_cdout = ref_rd(m_addr);
                end
            end else begin
                set_strobes();
            end
        end else begin
            g = 0;
            if (v_req && !pv) begin
                g = 1; m_vown = 1; m_wr = 0; m_addr = v_addr;
            end else if (c_req && !pc) begin
                g = 1; m_vown = 0; m_wr = c_we; m_addr = c_addr; m_din = c_din;
            end
            if (g) begin
                m_busy = 1;
                m_k = 1;
                m_len = m_wr ? WR + 2 : RD;
                set_strobes();
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare and bus checker ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("sramce", sramce, e_ce);
                chk("sramoe", sramoe, e_oe);
                chk("sramwe", sramwe, e_we);
                chk("sramub", sramub, e_ub);
                chk("sramlb", sramlb, e_lb);
                chk("v_ack", v_ack, e_vack);
                chk("c_ack", c_ack, e_cack);
                chk("v_dout", v_dout, e_vdout);
                chk("c_dout", c_dout, e_cdout);
                chk("c_wait", c_wait, c_req & ~e_cack);
                if (!e_ce) chk("sa", sa, e_sa);
                if (!sramoe) begin
                    chk("bus_oe_we", sramwe, 1'b1);
                    chk("bus_rd_sd", sd, rd_word);
                end
                if (!sramwe) chk("bus_wr_sd", sd, e_sd);
            end
        end
    end

    // ---------------- requesters ----------------
    task automatic cpu_access(input bit we, input logic [18:0] a, input logic [7:0] d,
                              output int lat, output int we_lo, output int oe_lo,
                              output bit ub_lo, output bit lb_lo);
        lat = 0; we_lo = 0; oe_lo = 0; ub_lo = 0; lb_lo = 0;
        c_we = we; c_addr = a; c_din = d; c_req = 1'b1;
        @(posedge clk); #1;
        while (!c_ack && lat < 50) begin
            chk("c_wait_held", c_wait, 1'b1);
            if (!sramwe) we_lo++;
            if (!sramoe) oe_lo++;
            if (!sramub) ub_lo = 1;
            if (!sramlb) lb_lo = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (!c_ack) chk("c_ack_timeout", 32'd0, 32'd1);
        c_req = 1'b0;
    endtask

    task automatic vid_access(input logic [18:0] a, output int lat, output logic [7:0] d);
        lat = 0;
        v_addr = a; v_req = 1'b1;
        @(posedge clk); #1;
        while (!v_ack && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!v_ack) chk("v_ack_timeout", 32'd0, 32'd1);
        d = v_dout;
        v_req = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int lat, vlat, we_lo, oe_lo, cw_lo, co_lo, acks;
    bit ub_lo, lb_lo, cu, cl;
    logic [7:0] vd;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_ce", sramce, 1'b1);
        chk("rst_sa", sa, 18'h0);
        chk("rst_cdout", c_dout, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset in the middle of a write
        c_we = 1'b1; c_addr = 19'h00010; c_din = 8'h77; c_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_write_we", sramwe, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ce", sramce, 1'b1);
        chk("abort_we", sramwe, 1'b1);
        chk("abort_ub_lb", {sramub, sramlb}, 2'b11);
        chk("abort_cack", c_ack, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        c_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_ack", c_ack, 1'b0);

        // CPU write to upper lane of word 0
        cpu_access(1'b1, 19'h00001, 8'hA5, lat, we_lo, oe_lo, ub_lo, lb_lo);
        chk("wr_latency", lat, 4);
        chk("wr_we_low_cycles", we_lo, 2);
        chk("wr_oe_low_cycles", oe_lo, 0);
        chk("wr_lanes", {ub_lo, lb_lo}, 2'b10);
        chk("wr_sram_word", pin_rd(19'h00001), 8'hA5);
        @(posedge clk); #1;

        // CPU read back
        cpu_access(1'b0, 19'h00001, 8'h00, lat, we_lo, oe_lo, ub_lo, lb_lo);
        chk("rd_latency", lat, 2);
        chk("rd_oe_low_cycles", oe_lo, 2);
        chk("rd_data", c_dout, 8'hA5);
        @(posedge clk); #1;

        // top-of-memory address and lower lane of word 0
        cpu_access(1'b1, 19'h7FFFF, 8'h3C, lat, we_lo, oe_lo, ub_lo, lb_lo);
        @(posedge clk); #1;
        cpu_access(1'b0, 19'h7FFFF, 8'h00, lat, we_lo, oe_lo, ub_lo, lb_lo);
        chk("top_rd_data", c_dout, 8'h3C);
        chk("top_lane", {ub_lo, lb_lo}, 2'b10);
        @(posedge clk); #1;
        cpu_access(1'b0, 19'h00000, 8'h00, lat, we_lo, oe_lo, ub_lo, lb_lo);
        chk("lb_rd_data", c_dout, 8'h3D);
        chk("lb_lane", {ub_lo, lb_lo}, 2'b01);
        @(posedge clk); #1;

        // simultaneous requests: video first, CPU after
        fork
            vid_access(19'h00100, vlat, vd);
            cpu_access(1'b0, 19'h00001, 8'h00, lat, cw_lo, co_lo, cu, cl);
        join
        chk("both_v_latency", vlat, 2);
        chk("both_c_latency", lat, 5);
        chk("both_v_data", vd, init_byte(19'h00100));
        chk("both_c_data", c_dout, 8'hA5);
        @(posedge clk); #1;

        // video request held across acks: one grant per request cycle
        acks = 0;
        v_addr = 19'h00203; v_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (v_ack) acks++;
        end
        v_req = 1'b0;
        chk("held_v_acks", acks, 3);
        chk("held_v_data", v_dout, init_byte(19'h00203));

        repeat (6) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
